pipelined_unsigned_mul: RTL and testbench
=========================================

# pipelined_unsigned_mul

Pipelined, parametrised unsigned integer multiplier with valid/ready handshaking on input and output. It is the registered successor to the combinational 24x24 Karatsuba/Booth multiplier used in the FP datapath: the width and pipeline depth are configurable, it supports a dual-lane half-width SIMD mode, and it carries a sideband tag for out-of-band bookkeeping. It sits between operand unpacking and normalisation in the fused FP pipeline, and backpressure can stall it.

## Interface
- WIDTH, 24: operand width. Must be even and at least 4.
- STAGES, 3: pipeline depth, 1..3. Equals the latency in cycles when there is no stall.
- TAG_W, 4: sideband tag width, at least 1.

- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous, active-low reset. This is the only clock/reset pair.
- IN_VALID  in  1  IN1/IN2/MODE/TAG_IN are valid.
- IN_READY  out  1  block accepts the input this cycle.
- IN1  in  WIDTH  multiplicand.
- IN2  in  WIDTH  multiplier.
- MODE  in  1  0 = full WIDTHxWIDTH product; 1 = dual lane.
- TAG_IN  in  TAG_W  sideband; returned unchanged with its result.
- OUT_VALID  out  1  OUT/TAG_OUT hold a result.
- OUT_READY  in  1  consumer takes the result this cycle.
- OUT  out  2*WIDTH  product.
- TAG_OUT  out  TAG_W  tag of the result currently on OUT.
- OCCUPANCY  out  $clog2(STAGES+1)  number of valid stage registers.

## Operation
- Let H = WIDTH/2. Split the operands as A1/A0 = IN1 upper/lower halves and B1/B0 = IN2 upper/lower halves.
- Karatsuba decomposition:
  - z0 = A0*B0
  - z2 = A1*B1
  - zm = (A0+A1)*(B0+B1), an (H+1)x(H+1) unsigned product
  - z1 = zm − z0 − z2, computed in 2H+2 bits
- MODE=0: OUT = {z2,z0} + (z1 << H), truncated to 2*WIDTH bits. This must equal IN1*IN2 exactly.
- MODE=1: OUT = {z2[WIDTH-1:0], z0[WIDTH-1:0]}. Lane products are independent; nothing carries between lanes. zm is not needed and its result is ignored.
- Stage partitioning:
  - STAGES=1: the full product is computed combinationally from the inputs into the single output register.
  - STAGES=2: S1 registers z0, z2, zm, MODE and TAG. S2 forms z1, combines, and registers the result.
  - STAGES=3: S1 registers operands, MODE and TAG. S2 registers z0, z2, zm. S3 combines and registers the result.
- Sub-product implementation (Booth, array or behavioural `*`) is free, provided each stage is purely combinational between its registers.
- Every stage k holds a valid bit v[k]. The last stage drives OUT_VALID.
- Stage k advances when v[k] is set and (stage k+1 is empty or stage k+1 advances). The last stage advances when OUT_READY is high.
- IN_READY = !v[1] || stage 1 advances. It is combinational from OUT_READY through the chain.
- Bubbles collapse: a stalled downstream stage does not freeze upstream stages that are empty ahead of it.
- The input is accepted on IN_VALID && IN_READY.
- A stage's data, MODE and TAG registers load only when that stage loads. They hold otherwise, including while v=0.
- Results leave in acceptance order. No result is dropped or duplicated.
- OCCUPANCY = popcount(v).

## Timing
- Reset (RST_N low at a rising edge):
  - all v cleared, so OUT_VALID=0 and OCCUPANCY=0
  - OUT=0, TAG_OUT=0
  - IN_READY=1 from the first cycle after reset
- Reset mid-stream discards in-flight results; none appear after reset deasserts.
- Latency: an input accepted at edge t produces OUT_VALID at edge t+STAGES−1 and is visible in the following cycle, when the pipe ahead of it is empty and never stalled.
- Throughput is one result per cycle while OUT_READY=1.
- With OUT_READY=0, the pipe fills to STAGES entries and then IN_READY=0 in the same cycle.
- Accept and drain in the same cycle with a full pipe is allowed, keeping throughput at 1.
- OUT, TAG_OUT and OUT_VALID stay stable while OUT_VALID=1 && OUT_READY=0.
- IN_VALID=1 during reset is ignored.

## Test plan
- Reset, WIDTH=24, STAGES=3 -> OUT_VALID=0, OUT=0, IN_READY=1, OCCUPANCY=0.
- IN1=IN2=0xFFFFFF, MODE=0, TAG=0x5, OUT_READY=1 -> OUT=0xFFFFFE000001, TAG_OUT=0x5 on the 3rd cycle after acceptance.
- IN1=0x123456, IN2=0x000001, then IN1=IN2=0xFFFFFF with MODE=1, back-to-back -> results in consecutive cycles: OUT=0x000000123456, then OUT=0xFFE001FFE001 (no cross-lane carry).
- OUT_READY=0 for 6 cycles while 5 inputs are offered -> only 3 accepted, OCCUPANCY=3, IN_READY=0, OUT held stable. Then OUT_READY=1 -> all 5 results emerge in order with matching tags.
- RST_N low for 1 cycle with 3 results in flight -> no stale OUT_VALID afterwards. A new input gives a correct result with standard latency.
- Random sweep, STAGES∈{1,2,3}, WIDTH∈{8,24,32}, random valid/ready -> every OUT matches the reference product (MODE=0) or the packed lane products (MODE=1), in order.

Source files
------------

// File: rtl/pipelined_unsigned_mul_if.sv
// Handshake bundle for pipelined_unsigned_mul: operand/tag input channel and product/tag output channel.
interface pipelined_unsigned_mul_if #(
    parameter int WIDTH = 24,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     in2;
    logic                 mode;
    logic [TAG_W-1:0]     tag_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out;
    logic [TAG_W-1:0]     tag_out;

    modport master (
        output in_valid, in1, in2, mode, tag_in, out_ready,
        input  in_ready, out_valid, out, tag_out
    );

    modport slave (
        input  in_valid, in1, in2, mode, tag_in, out_ready,
        output in_ready, out_valid, out, tag_out
    );
endinterface

// File: rtl/pipelined_unsigned_mul.sv
// Pipelined Karatsuba unsigned multiplier (1..3 stages) with dual-lane half-width mode,
// sideband tag and bubble-collapsing valid/ready flow control.
module pipelined_unsigned_mul #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    pipelined_unsigned_mul_if.slave         bus,
    output logic [$clog2(STAGES+1)-1:0]     occupancy
);
    localparam int H = WIDTH / 2;

    typedef struct packed {
        logic [WIDTH-1:0] z2;
        logic [WIDTH-1:0] z0;
        logic [WIDTH+1:0] zm;
    } parts_t;

    function automatic parts_t split_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        parts_t     p;
        logic [H:0] sa;
        logic [H:0] sb;
        sa   = {1'b0, a[WIDTH-1:H]} + {1'b0, a[H-1:0]};
        sb   = {1'b0, b[WIDTH-1:H]} + {1'b0, b[H-1:0]};
        p.z0 = {{H{1'b0}}, a[H-1:0]} * {{H{1'b0}}, b[H-1:0]};
        p.z2 = {{H{1'b0}}, a[WIDTH-1:H]} * {{H{1'b0}}, b[WIDTH-1:H]};
        p.zm = {{(H+1){1'b0}}, sa} * {{(H+1){1'b0}}, sb};
        return p;
    endfunction

    // Lane mode packs z2/z0 untouched so no carry crosses the lane boundary.
    function automatic logic [2*WIDTH-1:0] combine(input parts_t p, input logic m);
        logic [WIDTH+1:0]   z1;
        logic [2*WIDTH-1:0] z1s;
        z1  = p.zm - {2'b00, p.z0} - {2'b00, p.z2};
        z1s = {{(WIDTH-2){1'b0}}, z1} << H;
        if (m)
            return {p.z2, p.z0};
        return {p.z2, p.z0} + z1s;
    endfunction

    logic [STAGES:1]    v;
    logic [STAGES:1]    adv;
    logic [STAGES:1]    ld;
    logic [2*WIDTH-1:0] res_d;
    logic [TAG_W-1:0]   tag_d;
    logic [2*WIDTH-1:0] out_q;
    logic [TAG_W-1:0]   tag_q;

    // go = "the stage below can take a new entry"; it is true past any hole in the pipe.
    always_comb begin
        logic go;
        go  = bus.out_ready;
        adv = '0;
        for (int k = STAGES; k >= 1; k--) begin
            adv[k] = v[k] && go;
            go     = go || !v[k];
        end
    end

    assign bus.in_ready = !v[1] || adv[1];
    assign ld[1]        = bus.in_valid && bus.in_ready;

    for (genvar k = 2; k <= STAGES; k++) begin : g_ld
        assign ld[k] = adv[k-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++)
                v[k] <= ld[k] || (v[k] && !adv[k]);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 1; k <= STAGES; k++)
            if (v[k])
                occupancy = occupancy + 1'b1;
    end

    if (STAGES == 1) begin : g_s1
        assign res_d = combine(split_mul(bus.in1, bus.in2), bus.mode);
        assign tag_d = bus.tag_in;
    end else if (STAGES == 2) begin : g_s2
        parts_t           p1;
        logic             m1;
        logic [TAG_W-1:0] t1;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                p1 <= '0;
                m1 <= 1'b0;
                t1 <= '0;
            end else if (ld[1]) begin
                p1 <= split_mul(bus.in1, bus.in2);
                m1 <= bus.mode;
                t1 <= bus.tag_in;
            end
        end
        assign res_d = combine(p1, m1);
        assign tag_d = t1;
    end else begin : g_s3
        logic [WIDTH-1:0] a1;
        logic [WIDTH-1:0] b1;
        logic             m1;
        logic [TAG_W-1:0] t1;
        parts_t           p2;
        logic             m2;
        logic [TAG_W-1:0] t2;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                a1 <= '0;
                b1 <= '0;
                m1 <= 1'b0;
                t1 <= '0;
                p2 <= '0;
                m2 <= 1'b0;
                t2 <= '0;
            end else begin
                if (ld[1]) begin
                    a1 <= bus.in1;
                    b1 <= bus.in2;
                    m1 <= bus.mode;
                    t1 <= bus.tag_in;
                end
                if (ld[2]) begin
                    p2 <= split_mul(a1, b1);
                    m2 <= m1;
                    t2 <= t1;
                end
            end
        end
        assign res_d = combine(p2, m2);
        assign tag_d = t2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            tag_q <= '0;
        end else if (ld[STAGES]) begin
            out_q <= res_d;
            tag_q <= tag_d;
        end
    end

    assign bus.out_valid = v[STAGES];
    assign bus.out       = out_q;
    assign bus.tag_out   = tag_q;
endmodule

// File: tb/tb_pipelined_unsigned_mul.sv
// Directed vector table plus hand sequences on a 24x24/3-stage instance, and a random
// valid/ready sweep on three width/depth configurations against a reference product.
module tb_pipelined_unsigned_mul;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rrst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   rand_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    pipelined_unsigned_mul_if #(.WIDTH(24), .TAG_W(4)) bif ();
    logic [1:0] occ;

    pipelined_unsigned_mul #(.WIDTH(24), .STAGES(3), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif), .occupancy(occ)
    );

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic        m;
        logic [3:0]  t;
        logic [47:0] e;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];
    int   acc [NV];
    int   ii, oi, ai, acc1;
    logic stale, seen;

    task automatic drive(input int i, input logic vld);
        bif.in_valid = vld;
        bif.in1      = vt[i].a;
        bif.in2      = vt[i].b;
        bif.mode     = vt[i].m;
        bif.tag_in   = vt[i].t;
    endtask

    initial begin
        vt[0]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'h5, 48'hFFFFFE000001};
        vt[1]  = '{24'h123456, 24'h000001, 1'b0, 4'h1, 48'h000000123456};
        vt[2]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 4'h2, 48'hFFE001FFE001};
        vt[3]  = '{24'h000000, 24'hABCDEF, 1'b0, 4'h3, 48'h000000000000};
        vt[4]  = '{24'h800000, 24'h000002, 1'b0, 4'h4, 48'h000001000000};
        vt[5]  = '{24'h001000, 24'h001000, 1'b0, 4'h6, 48'h000001000000};
        vt[6]  = '{24'h003002, 24'h004003, 1'b1, 4'h7, 48'h00000C000006};
        vt[7]  = '{24'hFFF000, 24'h000FFF, 1'b1, 4'h8, 48'h000000000000};
        vt[8]  = '{24'h000FFF, 24'h000FFF, 1'b0, 4'h9, 48'h000000FFE001};
        vt[9]  = '{24'hFFF000, 24'hFFF000, 1'b0, 4'hA, 48'hFFE001000000};
        vt[10] = '{24'h800001, 24'h800001, 1'b0, 4'hB, 48'h400001000001};

        // Reset with in_valid high: must be ignored.
        drive(0, 1'b1);
        bif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rrst_n = 1'b1;
        bif.in_valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(bif.out_valid), 64'd0);
        check("rst_out", 64'(bif.out), 64'd0);
        check("rst_tag_out", 64'(bif.tag_out), 64'd0);
        check("rst_in_ready", 64'(bif.in_ready), 64'd1);
        check("rst_occ", 64'(occ), 64'd0);
        @(negedge clk);
        #1;
        check("rst_occ_after", 64'(occ), 64'd0);

        // Back-to-back table stream, latency 3, one result per cycle.
        ii = 0;
        oi = 0;
        for (int n = 0; n < NV + 12 && oi < NV; n++) begin
            @(negedge clk);
            if (ii < NV) drive(ii, 1'b1);
            else bif.in_valid = 1'b0;
            bif.out_ready = 1'b1;
            #1;
            if (bif.out_valid) begin
                check($sformatf("tbl_out[%0d]", oi), 64'(bif.out), 64'(vt[oi].e));
                check($sformatf("tbl_tag[%0d]", oi), 64'(bif.tag_out), 64'(vt[oi].t));
                check($sformatf("tbl_lat[%0d]", oi), 64'(cyc - acc[oi]), 64'd3);
                oi++;
            end
            if (bif.in_valid && bif.in_ready) begin
                acc[ii] = cyc;
                ii++;
            end
        end
        check("tbl_count", 64'(oi), 64'(NV));

        // Backpressure: 6 stalled cycles, 5 offered, only 3 fit.
        ai = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            drive(ai, 1'b1);
            bif.out_ready = 1'b0;
            #1;
            if (bif.in_valid && bif.in_ready) ai++;
        end
        @(negedge clk);
        drive(ai, 1'b1);
        #1;
        check("bp_accepted", 64'(ai), 64'd3);
        check("bp_occ", 64'(occ), 64'd3);
        check("bp_in_ready", 64'(bif.in_ready), 64'd0);
        check("bp_out_valid", 64'(bif.out_valid), 64'd1);
        check("bp_out", 64'(bif.out), 64'(vt[0].e));
        @(negedge clk);
        #1;
        check("bp_hold_valid", 64'(bif.out_valid), 64'd1);
        check("bp_hold_out", 64'(bif.out), 64'(vt[0].e));
        check("bp_hold_tag", 64'(bif.tag_out), 64'(vt[0].t));
        oi = 0;
        for (int n = 0; n < 20 && oi < 5; n++) begin
            @(negedge clk);
            if (ai < 5) drive(ai, 1'b1);
            else bif.in_valid = 1'b0;
            bif.out_ready = 1'b1;
            #1;
            if (bif.out_valid) begin
                check($sformatf("bp_drain_out[%0d]", oi), 64'(bif.out), 64'(vt[oi].e));
                check($sformatf("bp_drain_tag[%0d]", oi), 64'(bif.tag_out), 64'(vt[oi].t));
                oi++;
            end
            if (bif.in_valid && bif.in_ready) ai++;
        end
        check("bp_drain_count", 64'(oi), 64'd5);
        @(negedge clk);
        bif.in_valid = 1'b0;
        #1;
        check("bp_no_dup", 64'(bif.out_valid), 64'd0);

        // Reset with three results in flight.
        bif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b1);
            @(negedge clk);
        end
        bif.in_valid = 1'b0;
        #1;
        check("mid_occ_before", 64'(occ), 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bif.out_ready = 1'b1;
        #1;
        check("mid_occ_after", 64'(occ), 64'd0);
        stale = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            #1;
            stale = stale | bif.out_valid;
        end
        check("mid_stale", 64'(stale), 64'd0);
        @(negedge clk);
        drive(10, 1'b1);
        #1;
        check("mid_new_ready", 64'(bif.in_ready), 64'd1);
        acc1 = cyc;
        seen = 1'b0;
        @(negedge clk);
        bif.in_valid = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            #1;
            if (bif.out_valid) begin
                seen = 1'b1;
                check("mid_new_out", 64'(bif.out), 64'(vt[10].e));
                check("mid_new_tag", 64'(bif.tag_out), 64'(vt[10].t));
                check("mid_new_lat", 64'(cyc - acc1), 64'd3);
            end
            @(negedge clk);
        end
        check("mid_new_seen", 64'(seen), 64'd1);

        for (int n = 0; n < 5000 && rand_done < 3; n++) @(posedge clk);
        check("rand_done", 64'(rand_done), 64'd3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Random valid/ready sweep over (WIDTH,STAGES) = (8,1), (32,2), (24,3).
    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int W = (gi == 0) ? 8 : (gi == 1) ? 32 : 24;
        localparam int S = gi + 1;
        localparam int H = W / 2;

        pipelined_unsigned_mul_if #(.WIDTH(W), .TAG_W(4)) rif ();
        logic [$clog2(S+1)-1:0] rocc;

        pipelined_unsigned_mul #(.WIDTH(W), .STAGES(S), .TAG_W(4)) rdut (
            .clk(clk), .rst_n(rrst_n), .bus(rif), .occupancy(rocc)
        );

        logic [63:0] eq [$];
        logic [3:0]  tq [$];
        logic [63:0] a64, b64, e64, msk;

        initial begin
            rif.in_valid  = 1'b0;
            rif.in1       = '0;
            rif.in2       = '0;
            rif.mode      = 1'b0;
            rif.tag_in    = '0;
            rif.out_ready = 1'b0;
            msk = (64'd1 << H) - 64'd1;
            @(posedge rrst_n);
            for (int n = 0; n < 412; n++) begin
                @(negedge clk);
                if (n < 400) begin
                    rif.in_valid  = 1'($urandom_range(0, 1));
                    rif.in1       = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    rif.in2       = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    rif.mode      = 1'($urandom_range(0, 1));
                    rif.tag_in    = 4'($urandom);
                    rif.out_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    rif.in_valid  = 1'b0;
                    rif.out_ready = 1'b1;
                end
                #1;
                if (rif.out_valid && rif.out_ready) begin
                    if (eq.size() == 0) begin
                        check($sformatf("rand%0d_extra", gi), 64'd1, 64'd0);
                    end else begin
                        check($sformatf("rand%0d_out", gi), 64'(rif.out), eq.pop_front());
                        check($sformatf("rand%0d_tag", gi), 64'(rif.tag_out), 64'(tq.pop_front()));
                    end
                end
                if (rif.in_valid && rif.in_ready) begin
                    a64 = 64'(rif.in1);
                    b64 = 64'(rif.in2);
                    if (!rif.mode)
                        e64 = a64 * b64;
                    else
                        e64 = (((a64 >> H) * (b64 >> H)) << W) | ((a64 & msk) * (b64 & msk));
                    eq.push_back(e64);
                    tq.push_back(rif.tag_in);
                end
            end
            check($sformatf("rand%0d_drain", gi), 64'(eq.size()), 64'd0);
            rand_done++;
        end
    end
endmodule
